// File: rtl/msu_data_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_prefetch
// Function : Byte prefetch ring buffer between the MSU-1 register block and a
//            16-bit word backing store. Keeps data bytes queued ahead of the
//            read pointer so $2001 reads are served without waiting on memory.
// Revision : 1.0 - initial release
// ============================================================================
module msu_data_prefetch #(
    parameter int DEPTH = 16,
    parameter int PRIME = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] data_addr,
    input  logic        data_seek,
    input  logic        data_req,
    output logic [7:0]  data_out,
    output logic        data_busy,
    output logic        underrun,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FETCH_LIMIT = c_CW'(DEPTH - 2);
    localparam logic [c_CW-1:0] c_PRIME       = c_CW'(PRIME);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    logic [7:0]      r_buf [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [31:0]     r_fetch_addr;
    logic            r_skip_lo;
    logic [1:0]      r_state;
    logic            r_active;
    logic [7:0]      r_data_out;
    logic            r_busy;
    logic            r_underrun;
    logic            r_mem_rd;
    logic [31:0]     r_mem_addr;

    logic            w_take;
    logic            w_pop;
    logic            w_issue;
    logic            w_active_nxt;
    logic [c_AW-1:0] w_wr_step;
    logic [c_AW-1:0] w_wr_1;
    logic [c_AW-1:0] w_wr_nxt;
    logic [c_AW-1:0] w_rd_nxt;
    logic [c_CW-1:0] w_count_nxt;
    logic [31:0]     w_fetch_nxt;
    logic [1:0]      w_state_nxt;
    logic [7:0]      w_first_byte;
    logic [7:0]      w_head;

    // Qualify this cycle's ack and pop; a seek overrides both.
    always_comb begin
        w_take       = mem_ack && (r_state == c_ST_WAIT) && !data_seek;
        w_pop        = data_req && !data_seek && (r_count != '0);
        w_wr_step    = '0;
        if (w_take) begin
            w_wr_step = r_skip_lo ? c_AW'(1) : c_AW'(2);
        end
        w_wr_1       = r_wr_ptr + c_AW'(1);
        w_wr_nxt     = r_wr_ptr + w_wr_step;
        w_rd_nxt     = r_rd_ptr + {{(c_AW-1){1'b0}}, w_pop};
        w_first_byte = r_skip_lo ? mem_dout[15:8] : mem_dout[7:0];
    end

    // Head byte after this cycle, forwarding bytes being written right now.
    always_comb begin
        w_head = r_buf[w_rd_nxt];
        if (w_take && (w_rd_nxt == r_wr_ptr)) begin
            w_head = w_first_byte;
        end else if (w_take && !r_skip_lo && (w_rd_nxt == w_wr_1)) begin
            w_head = mem_dout[15:8];
        end
    end

    // Next occupancy, fetch address and FSM state; fetch decision uses them
    // so a request can leave the cycle right after an ack, pop or seek.
    always_comb begin
        w_active_nxt = r_active | data_seek;
        if (data_seek) begin
            w_count_nxt = '0;
            w_fetch_nxt = {data_addr[31:1], 1'b0};
        end else begin
            w_count_nxt = r_count + {1'b0, w_wr_step} - {{c_AW{1'b0}}, w_pop};
            w_fetch_nxt = w_take ? (r_fetch_addr + 32'd2) : r_fetch_addr;
        end
        // A seek that coincides with the ack retires the outstanding request,
        // so there is nothing left to drop.
        case (r_state)
            c_ST_WAIT: w_state_nxt = mem_ack ? c_ST_IDLE :
                                     (data_seek ? c_ST_DROP : c_ST_WAIT);
            c_ST_DROP: w_state_nxt = mem_ack ? c_ST_IDLE : c_ST_DROP;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
        w_issue = (w_state_nxt == c_ST_IDLE) && w_active_nxt &&
                  (w_count_nxt <= c_FETCH_LIMIT);
    end

    // Ring buffer storage; contents are meaningless until counted valid.
    always_ff @(posedge CLK) begin
        if (w_take) begin
            r_buf[r_wr_ptr] <= w_first_byte;
            if (!r_skip_lo) begin
                r_buf[w_wr_1] <= mem_dout[15:8];
            end
        end
    end

    // Control state, fetch FSM and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fetch_addr <= 32'd0;
            r_skip_lo    <= 1'b0;
            r_state      <= c_ST_IDLE;
            r_active     <= 1'b0;
            r_data_out   <= 8'h00;
            r_busy       <= 1'b0;
            r_underrun   <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= 32'd0;
        end else begin
            r_count      <= w_count_nxt;
            r_fetch_addr <= w_fetch_nxt;
            r_active     <= w_active_nxt;
            r_state      <= w_issue ? c_ST_WAIT : w_state_nxt;
            r_mem_rd     <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_fetch_nxt;
            end
            if (data_seek) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_skip_lo  <= data_addr[0];
                r_busy     <= 1'b1;
                r_underrun <= 1'b0;
            end else begin
                r_wr_ptr <= w_wr_nxt;
                r_rd_ptr <= w_rd_nxt;
                if (w_take) begin
                    r_skip_lo <= 1'b0;
                end
                if (data_req && (r_count == '0)) begin
                    r_underrun <= 1'b1;
                end
                if (r_busy && (w_count_nxt >= c_PRIME)) begin
                    r_busy <= 1'b0;
                end
                if (w_count_nxt != '0) begin
                    r_data_out <= w_head;
                end
            end
        end
    end

    assign data_out  = r_data_out;
    assign data_busy = r_busy;
    assign underrun  = r_underrun;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_msu_data_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_msu_data_prefetch
// Function : Self-checking bench for msu_data_prefetch. A byte-queue model of
//            the data stream predicts every output; a memory responder with
//            random latency serves the fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msu_data_prefetch;

    localparam int c_DEPTH = 16;
    localparam int c_PRIME = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] data_addr;
    logic        data_seek;
    logic        data_req;
    logic [7:0]  data_out;
    logic        data_busy;
    logic        underrun;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_dout;

    always #5 CLK = ~CLK;

    msu_data_prefetch #(
        .DEPTH (c_DEPTH),
        .PRIME (c_PRIME)
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .data_addr (data_addr),
        .data_seek (data_seek),
        .data_req  (data_req),
        .data_out  (data_out),
        .data_busy (data_busy),
        .underrun  (underrun),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack),
        .mem_dout  (mem_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bytes the reader will see, in order.
    logic [7:0]  m_q[$];
    logic [31:0] m_fetch  = 32'd0;
    logic        m_skip   = 1'b0;
    logic        m_pend   = 1'b0;
    logic        m_stale  = 1'b0;
    logic        m_active = 1'b0;
    logic        m_busy   = 1'b0;
    logic        m_under  = 1'b0;
    logic [7:0]  m_dout   = 8'h00;
    logic        m_rd     = 1'b0;
    logic [31:0] m_addr   = 32'd0;

    // Memory responder state.
    logic        mem_busy     = 1'b0;
    int          mem_cnt      = 0;
    logic [31:0] mem_req_addr = 32'd0;
    int          lat_lo       = 1;
    int          lat_hi       = 4;
    logic        post_rst     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Contents of the backing store at a byte address.
    function automatic logic [7:0] mb(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    task automatic model_step(input logic seek, input logic [31:0] addr, input logic req,
                              input logic rstn, input logic ack, input logic [15:0] word);
        if (!rstn) begin
            m_q.delete();
            m_fetch = 32'd0; m_skip = 1'b0; m_pend = 1'b0; m_stale = 1'b0;
            m_active = 1'b0; m_busy = 1'b0; m_under = 1'b0; m_dout = 8'h00;
            m_rd = 1'b0; m_addr = 32'd0;
        end else begin
            if (seek) begin
                m_q.delete();
                m_fetch  = {addr[31:1], 1'b0};
                m_skip   = addr[0];
                m_busy   = 1'b1;
                m_under  = 1'b0;
                m_active = 1'b1;
                if (m_pend) begin
                    if (ack) begin
                        m_pend = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end
            end else begin
                if (req) begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    else m_under = 1'b1;
                end
                if (ack && m_pend) begin
                    if (!m_stale) begin
                        if (!m_skip) m_q.push_back(word[7:0]);
                        m_q.push_back(word[15:8]);
                        m_fetch = m_fetch + 32'd2;
                        m_skip  = 1'b0;
                    end
                    m_pend  = 1'b0;
                    m_stale = 1'b0;
                end
                if (m_q.size() > 0) m_dout = m_q[0];
                if (m_busy && m_q.size() >= c_PRIME) m_busy = 1'b0;
            end
            m_rd = 1'b0;
            if (m_active && !m_pend && m_q.size() <= c_DEPTH - 2) begin
                m_rd   = 1'b1;
                m_pend = 1'b1;
                m_addr = m_fetch;
            end
        end
    endtask

    // One clock cycle: check outputs, serve memory, drive inputs, advance model.
    task automatic cycle(input logic seek, input logic [31:0] addr, input logic req, input logic rstn);
        logic ack;
        @(negedge CLK);
        check_eq("data_out",  {24'd0, data_out},  {24'd0, m_dout});
        check_eq("data_busy", {31'd0, data_busy}, {31'd0, m_busy});
        check_eq("underrun",  {31'd0, underrun},  {31'd0, m_under});
        check_eq("mem_rd",    {31'd0, mem_rd},    {31'd0, m_rd});
        if (m_rd) check_eq("mem_addr", mem_addr, m_addr);
        ack = 1'b0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                ack = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        if (mem_rd) begin
            check_eq("mem_overlap", {31'd0, mem_busy}, 32'd0);
            mem_busy     = 1'b1;
            mem_req_addr = mem_addr;
            mem_cnt      = $urandom_range(lat_hi, lat_lo) - 1;
        end
        if (!mem_busy) post_rst = 1'b0;
        mem_ack   = ack;
        mem_dout  = ack ? {mb(mem_req_addr + 32'd1), mb(mem_req_addr)} : 16'($urandom);
        data_seek = seek;
        data_addr = addr;
        data_req  = req;
        RST_N     = rstn;
        if (!rstn) post_rst = 1'b1;
        @(posedge CLK);
        model_step(seek, addr, req, rstn, ack, mem_dout);
    endtask

    initial begin
        logic        seek;
        logic        req;
        logic        rstn;
        logic [31:0] addr;
        int          rate;
        RST_N = 1'b0; data_addr = 32'd0; data_seek = 1'b0; data_req = 1'b0;
        mem_ack = 1'b0; mem_dout = 16'd0;

        // Reset, then idle: nothing may be fetched before the first seek.
        repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 32'd0, 1'b0, 1'b1);

        // Aligned seek, fixed latency 3, fill to saturation, then drain a bit.
        lat_lo = 3; lat_hi = 3;
        cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 32'd0, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Odd seek: low byte of the first word is dropped.
        cycle(1'b1, 32'h0000_0101, 1'b0, 1'b1);
        repeat (12) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Reseek while a fetch is outstanding.
        cycle(1'b1, 32'h0000_0000, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_1000, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Underrun on an empty buffer, then cleared by a seek.
        cycle(1'b1, 32'h0000_2000, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_3000, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b0, 1'b1);

        // Address wrap with pops landing on ack cycles.
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (30) cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Seek in the same cycle as the ack.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b1, 32'h0000_0400, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0801, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 32'd0, 1'b0, 1'b1);

        // Reset with a request outstanding: the late ack must be ignored.
        lat_lo = 5; lat_hi = 5;
        cycle(1'b1, 32'h0000_0600, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0700, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 6;
        rate = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rate = $urandom_range(3, 0);
            rstn = ($urandom_range(799, 0) != 0);
            seek = rstn && !post_rst && ($urandom_range(59, 0) == 0);
            addr = ($urandom_range(1, 0) == 1) ? 32'($urandom)
                                               : (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)));
            case (rate)
                0:       req = 1'b0;
                1:       req = ($urandom_range(3, 0) == 0);
                2:       req = ($urandom_range(1, 0) == 0);
                default: req = 1'b1;
            endcase
            cycle(seek, addr, req, rstn);
        end
        repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
